// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU event tagger: event word layout, widths and FSM encoding.
package tlu_pkg;

  localparam int unsigned TS_WIDTH    = 40;
  localparam int unsigned EVT_WIDTH   = 64;
  localparam int unsigned CNT_WIDTH   = 16;
  localparam int unsigned CNT_LSB     = 48;
  localparam int unsigned SEQ_ERR_BIT = 47;
  localparam int unsigned LOST_BIT    = 46;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitCnt = 1'b1
  } tlu_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [EVT_WIDTH-1:0] pack_word(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic                 seq_err,
                                                     input logic                 lost,
                                                     input logic [TS_WIDTH-1:0]  ts);
    logic [EVT_WIDTH-1:0] w;
    w                      = '0;
    w[CNT_LSB+:CNT_WIDTH]  = cnt;
    w[SEQ_ERR_BIT]         = seq_err;
    w[LOST_BIT]            = lost;
    w[TS_WIDTH-1:0]        = ts;
    return w;
  endfunction

endpackage

// File: rtl/tlu_event_tagger_if.sv
// Trigger handshake from the TLU and the event-word stream towards the consumer.
interface tlu_event_tagger_if;
  import tlu_pkg::*;

  logic                 trigger_valid;
  logic                 trigger_cnt_valid;
  logic [CNT_WIDTH-1:0] trigger_cnt;
  logic [EVT_WIDTH-1:0] evt_data;
  logic                 evt_valid;
  logic                 evt_ready;

  // Environment side: drives the TLU handshake and consumes event words.
  modport master (
    output trigger_valid, trigger_cnt_valid, trigger_cnt, evt_ready,
    input  evt_data, evt_valid
  );

  // Tagger side.
  modport slave (
    input  trigger_valid, trigger_cnt_valid, trigger_cnt, evt_ready,
    output evt_data, evt_valid
  );

endinterface

// File: rtl/tlu_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is presented combinationally.
module tlu_evt_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(Depth));
  // A full FIFO refuses the push even if the head is popped in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/tlu_event_tagger.sv
// Tags TLU triggers with a 40-bit timestamp and trigger number, queuing event words in a FIFO.
module tlu_event_tagger
  import tlu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WD_LIMIT   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_sys,
  tlu_event_tagger_if.slave    bus,
  input  logic                 i_ts_clr,
  output logic                 o_fifo_full,
  output logic [CNT_WIDTH-1:0] o_drop_cnt,
  output logic [CNT_WIDTH-1:0] o_seq_err_cnt,
  output logic [CNT_WIDTH-1:0] o_tmo_cnt
);

  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

  tlu_state_e           r_state;
  tlu_state_e           w_state_next;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [TS_WIDTH-1:0]  r_ts_lat;
  logic [WD_W-1:0]      r_wd;
  logic                 r_trig_prev;
  logic [CNT_WIDTH-1:0] r_prev_cnt;
  logic                 r_first;
  logic                 r_lost;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] r_seq_err_cnt;
  logic [CNT_WIDTH-1:0] r_tmo_cnt;

  logic                 w_start;
  logic                 w_wd_expired;
  logic                 w_latch;
  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_seq_err;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic [EVT_WIDTH-1:0] w_word;
  logic [EVT_WIDTH-1:0] w_fifo_data;

  // Only a rising TRIGGER_VALID opens a handshake, so a level still high after an abort is ignored.
  assign w_start      = bus.trigger_valid && !r_trig_prev;
  assign w_wd_expired = (r_wd == WD_W'(WD_LIMIT - 1));
  assign w_seq_err    = !r_first && (bus.trigger_cnt != r_prev_cnt + CNT_WIDTH'(1));
  assign w_push       = w_accept && !w_full;
  assign w_word       = pack_word(bus.trigger_cnt, w_seq_err, r_lost, r_ts_lat);

  always_ff @(posedge i_clk) begin
    if (i_rst_sys) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_start) w_state_next = StWaitCnt;
      StWaitCnt: begin
        if (bus.trigger_cnt_valid || !bus.trigger_valid || w_wd_expired) begin
          w_state_next = StIdle;
        end
      end
      default:   w_state_next = StIdle;
    endcase
  end

  // Count beats both a falling TRIGGER_VALID and watchdog expiry in the same cycle.
  always_comb begin
    w_latch   = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      StIdle:    w_latch = w_start;
      StWaitCnt: begin
        if (bus.trigger_cnt_valid)                      w_accept  = 1'b1;
        else if (!bus.trigger_valid || w_wd_expired)    w_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_trig_prev <= bus.trigger_valid;
    if (i_rst_sys) begin
      r_ts          <= '0;
      r_ts_lat      <= '0;
      r_wd          <= '0;
      r_prev_cnt    <= '0;
      r_first       <= 1'b1;
      r_lost        <= 1'b0;
      r_drop_cnt    <= '0;
      r_seq_err_cnt <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_ts <= i_ts_clr ? '0 : r_ts + TS_WIDTH'(1);
      if (w_latch) begin
        r_ts_lat <= r_ts;
        r_wd     <= '0;
      end else if (r_state == StWaitCnt) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_accept) begin
        r_prev_cnt <= bus.trigger_cnt;
        r_first    <= 1'b0;
        if (w_seq_err) r_seq_err_cnt <= sat_inc(r_seq_err_cnt);
        if (w_full) begin
          r_lost     <= 1'b1;
          r_drop_cnt <= sat_inc(r_drop_cnt);
        end else begin
          r_lost <= 1'b0;
        end
      end
      if (w_timeout) r_tmo_cnt <= sat_inc(r_tmo_cnt);
    end
  end

  tlu_evt_fifo #(
    .Width (EVT_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst_sys),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (bus.evt_ready),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.evt_data   = w_fifo_data;
  assign bus.evt_valid  = !w_empty;
  assign o_fifo_full    = w_full;
  assign o_drop_cnt     = r_drop_cnt;
  assign o_seq_err_cnt  = r_seq_err_cnt;
  assign o_tmo_cnt      = r_tmo_cnt;

endmodule

// File: tb/tb_tlu_event_tagger.sv
// Bench for tlu_event_tagger: directed tables, corner sequences and a queue-based reference model.
module tb_tlu_event_tagger;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WD    = 64;

  logic        clk;
  logic        rst;
  logic        ts_clr;
  logic [15:0] drop_cnt;
  logic [15:0] seq_cnt;
  logic [15:0] tmo_cnt;
  logic        fifo_full;

  tlu_event_tagger_if u_if ();

  tlu_event_tagger #(
    .FIFO_DEPTH (DEPTH),
    .WD_LIMIT   (WD)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_sys     (rst),
    .bus           (u_if.slave),
    .i_ts_clr      (ts_clr),
    .o_fifo_full   (fifo_full),
    .o_drop_cnt    (drop_cnt),
    .o_seq_err_cnt (seq_cnt),
    .o_tmo_cnt     (tmo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rx  = 0;
  logic [39:0] ts_now = '0;
  bit          rnd_ready = 0;

  // Reference model state: expected FIFO contents and event bookkeeping.
  logic [63:0] q[$];
  logic        m_first;
  logic        m_lost;
  logic [15:0] m_prev;
  logic [15:0] m_drop;
  logic [15:0] m_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ts_now = (rst || ts_clr) ? 40'd0 : ts_now + 40'd1;
    #1;
    if (rnd_ready) u_if.evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_clear();
    q.delete();
    m_first = 1'b1;
    m_lost  = 1'b0;
    m_prev  = '0;
    m_drop  = '0;
    m_seq   = '0;
  endtask

  task automatic model_event(input logic [39:0] lat, input logic [15:0] c);
    logic seq;
    logic [15:0] nxt;
    nxt = m_prev + 16'd1;
    seq = !m_first && (c != nxt);
    if (seq && m_seq != 16'hFFFF) m_seq = m_seq + 16'd1;
    m_prev  = c;
    m_first = 1'b0;
    if (q.size() >= DEPTH) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      m_lost = 1'b1;
    end else begin
      q.push_back({c, seq, m_lost, 6'd0, lat});
      m_lost = 1'b0;
    end
  endtask

  task automatic reset_dut();
    q.delete();
    rst = 1'b1;
    u_if.trigger_valid     = 1'b0;
    u_if.trigger_cnt_valid = 1'b0;
    ts_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  // Rise, count pulse dly WAIT cycles later, then drop; accepted=0 when the count should be ignored.
  task automatic handshake(input int pre, input int dly, input logic [15:0] c, input bit accepted);
    logic [39:0] lat;
    repeat (pre) tick();
    u_if.trigger_valid = 1'b1;
    lat = ts_now;
    tick();
    repeat (dly) tick();
    u_if.trigger_cnt_valid = 1'b1;
    u_if.trigger_cnt       = c;
    if (accepted) model_event(lat, c);
    tick();
    u_if.trigger_cnt_valid = 1'b0;
    u_if.trigger_valid     = 1'b0;
  endtask

  task automatic drain();
    rnd_ready = 0;
    u_if.evt_ready = 1'b1;
    for (int k = 0; k < 4 * DEPTH && q.size() != 0; k++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: in-order scoreboard and hold-while-stalled check.
  logic        stalled = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(u_if.evt_valid), 64'd1);
        chk("stall_data", u_if.evt_data, held);
      end
      if (u_if.evt_valid && u_if.evt_ready) begin
        n_rx++;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", u_if.evt_data);
        end else begin
          chk("evt_order", u_if.evt_data, q.pop_front());
        end
      end
      stalled <= u_if.evt_valid && !u_if.evt_ready;
      held    <= u_if.evt_data;
    end
  end

  typedef struct {
    logic [15:0] cnt;
    logic        exp_seq;
    logic [15:0] exp_seq_cnt;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [15:0] c;
    int rx0;
    vt[0] = '{cnt: 16'hFFFE, exp_seq: 1'b0, exp_seq_cnt: 16'd0};
    vt[1] = '{cnt: 16'hFFFF, exp_seq: 1'b0, exp_seq_cnt: 16'd0};
    vt[2] = '{cnt: 16'h0000, exp_seq: 1'b0, exp_seq_cnt: 16'd0};
    vt[3] = '{cnt: 16'h0002, exp_seq: 1'b1, exp_seq_cnt: 16'd1};
    vt[4] = '{cnt: 16'h0003, exp_seq: 1'b0, exp_seq_cnt: 16'd1};

    u_if.trigger_cnt = '0;
    u_if.evt_ready   = 1'b1;
    model_clear();
    reset_dut();
    chk("rst_valid", 64'(u_if.evt_valid), 64'd0);
    chk("rst_data", u_if.evt_data, 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_seq", 64'(seq_cnt), 64'd0);
    chk("rst_tmo", 64'(tmo_cnt), 64'd0);

    // First event: rise at timestamp 100, count three cycles later.
    while (ts_now < 40'd100) tick();
    handshake(0, 2, 16'h0005, 1);
    chk("first_valid", 64'(u_if.evt_valid), 64'd1);
    chk("first_word", u_if.evt_data, 64'h0005_0000_0000_0064);
    tick();

    // Trigger-number continuity table.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      handshake(1, i, vt[i].cnt, 1);
      chk("seq_cnt_field", 64'(u_if.evt_data[63:48]), 64'(vt[i].cnt));
      chk("seq_err_bit", 64'(u_if.evt_data[47]), 64'(vt[i].exp_seq));
      chk("seq_err_cnt", 64'(seq_cnt), 64'(vt[i].exp_seq_cnt));
    end
    tick();

    // Overflow with the consumer stalled, then LOST reporting.
    reset_dut();
    u_if.evt_ready = 1'b0;
    for (int i = 0; i < 18; i++) handshake(1, 1, 16'(i + 1), 1);
    chk("ovf_full", 64'(fifo_full), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_seq", 64'(seq_cnt), 64'd0);
    rx0 = n_rx;
    drain();
    chk("ovf_stored", 64'(n_rx - rx0), 64'd16);
    chk("ovf_full_clr", 64'(fifo_full), 64'd0);
    handshake(1, 0, 16'd19, 1);
    chk("lost_set", 64'(u_if.evt_data[46]), 64'd1);
    tick();
    handshake(1, 0, 16'd20, 1);
    chk("lost_clr", 64'(u_if.evt_data[46]), 64'd0);
    tick();

    // Watchdog and aborted handshakes.
    reset_dut();
    u_if.trigger_valid = 1'b1;
    repeat (70) tick();
    chk("wd_tmo", 64'(tmo_cnt), 64'd1);
    chk("wd_noword", 64'(u_if.evt_valid), 64'd0);
    u_if.trigger_valid = 1'b0;
    repeat (2) tick();
    chk("wd_tmo_hold", 64'(tmo_cnt), 64'd1);
    u_if.trigger_valid = 1'b1;
    repeat (3) tick();
    u_if.trigger_valid = 1'b0;
    repeat (2) tick();
    chk("fall_tmo", 64'(tmo_cnt), 64'd2);
    handshake(1, WD - 1, 16'h0100, 1);
    chk("wd_edge_word", 64'(u_if.evt_valid), 64'd1);
    chk("wd_edge_tmo", 64'(tmo_cnt), 64'd2);
    tick();
    handshake(1, WD, 16'h0101, 0);
    chk("wd_late_noword", 64'(u_if.evt_valid), 64'd0);
    chk("wd_late_tmo", 64'(tmo_cnt), 64'd3);
    tick();

    // Reset in WAIT_CNT abandons the event without a timeout.
    reset_dut();
    u_if.trigger_valid = 1'b1;
    repeat (2) tick();
    q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    u_if.trigger_cnt_valid = 1'b1;
    u_if.trigger_cnt       = 16'h0077;
    tick();
    u_if.trigger_cnt_valid = 1'b0;
    chk("rstmid_noword", 64'(u_if.evt_valid), 64'd0);
    chk("rstmid_tmo", 64'(tmo_cnt), 64'd0);
    u_if.trigger_valid = 1'b0;
    handshake(1, 1, 16'h0200, 1);
    chk("rstmid_valid", 64'(u_if.evt_valid), 64'd1);
    chk("rstmid_seq", 64'(u_if.evt_data[47]), 64'd0);
    tick();

    // Timestamp clear.
    ts_clr = 1'b1;
    tick();
    ts_clr = 1'b0;
    handshake(0, 0, 16'h0201, 1);
    chk("tsclr_ts", 64'(u_if.evt_data[39:0]), 64'd0);
    tick();

    // Random back-pressure with continuous triggers.
    reset_dut();
    rnd_ready = 1;
    c = 16'($urandom);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) c = 16'($urandom);
      else                           c = c + 16'd1;
      handshake(int'($urandom_range(1, 3)), int'($urandom_range(0, 4)), c, 1);
    end
    drain();
    chk("rnd_seq_cnt", 64'(seq_cnt), 64'(m_seq));
    chk("rnd_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("rnd_tmo_cnt", 64'(tmo_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tlu_event_tagger.md
TLU_EVENT_TAGGER -- requirements
Module: tlu_event_tagger

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, event FIFO depth in words; power of two, 4..256.
REQ-002 Parameter WD_LIMIT, default 64, watchdog limit in CLK cycles for an incomplete handshake.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RST_SYS  in  1  reset; synchronous and active-high.
REQ-005 TRIGGER_VALID  in  1  high while the upstream TLU handshake is active.
REQ-006 TRIGGER_CNT_VALID  in  1  one-cycle pulse; TRIGGER_CNT is valid in that cycle.
REQ-007 TRIGGER_CNT  in  16  TLU trigger number.
REQ-008 TS_CLR  in  1  synchronous clear of the timestamp counter.
REQ-009 EVT_DATA  out  64  event word.
REQ-010 EVT_VALID  out  1  EVT_DATA valid.
REQ-011 EVT_READY  in  1  consumer accepts the word.
REQ-012 FIFO_FULL  out  1  event FIFO full.
REQ-013 DROP_CNT  out  16  saturating count of events dropped because the FIFO was full.
REQ-014 SEQ_ERR_CNT  out  16  saturating count of trigger-number discontinuities.
REQ-015 TMO_CNT  out  16  saturating count of aborted handshakes.

Function
REQ-016 Timestamp: 40-bit free-running counter; +1 per cycle; wraps to 0; TS_CLR forces 0 in the next cycle.
REQ-017 FSM states: IDLE, WAIT_CNT.
REQ-018 IDLE: on the first cycle with TRIGGER_VALID=1, latch the timestamp and go to WAIT_CNT.
REQ-019 WAIT_CNT: TRIGGER_CNT_VALID=1 -> form the event word and go to IDLE.
REQ-020 WAIT_CNT: TRIGGER_VALID=0 without a count, or WD_LIMIT cycles elapsed -> TMO_CNT+1, no word, go to IDLE.
REQ-021 TRIGGER_CNT_VALID is ignored in IDLE.
REQ-022 When TRIGGER_CNT_VALID and a TRIGGER_VALID fall occur in the same cycle, the count wins (the event is recorded, no timeout).
REQ-023 Word format: [63:48] TRIGGER_CNT; [47] SEQ_ERR; [46] LOST; [45:40] 0; [39:0] latched timestamp.
REQ-024 SEQ_ERR is set when TRIGGER_CNT != (previous TRIGGER_CNT + 1) mod 2^16.
REQ-025 No SEQ_ERR is flagged on the first event after reset; 0xFFFF -> 0x0000 is continuous.
REQ-026 The previous-count register updates on every accepted count, including dropped events.
REQ-027 Push occurs only if FIFO_FULL=0 in the count cycle; otherwise the word is discarded, DROP_CNT+1, and a sticky LOST flag is set.
REQ-028 The sticky LOST flag is written into bit 46 of the next stored word, then cleared.
REQ-029 No push bypass on a full FIFO: a same-cycle pop does not admit the push.
REQ-030 Output is first-word-fall-through: a word written in cycle N to an empty FIFO gives EVT_VALID=1 in cycle N+1.
REQ-031 A word transfers when EVT_VALID and EVT_READY are both high; EVT_DATA and EVT_VALID hold stable while EVT_VALID=1 and EVT_READY=0.
REQ-032 Push and pop in the same cycle keep the occupancy unchanged.
REQ-033 All counters saturate at 0xFFFF.

Reset
REQ-034 RST_SYS=1 at a rising edge sets: FSM=IDLE, timestamp=0, FIFO empty, EVT_VALID=0, EVT_DATA=0, FIFO_FULL=0, DROP_CNT=0, SEQ_ERR_CNT=0, TMO_CNT=0, LOST=0, first-event flag set.
REQ-035 Reset mid-handshake abandons the event without counting a timeout; the first cycle after reset release is IDLE.

Structure
REQ-036 Shared package tlu_pkg: word field bit positions, TS_WIDTH=40, FSM state encoding, EVT_WIDTH=64.
REQ-037 One sub-module, tlu_evt_fifo: synchronous first-word-fall-through FIFO, parameterised width/depth, with full/empty outputs.

Verification
REQ-038 Reset, then TRIGGER_VALID high at timestamp 100, count 0x0005 three cycles later -> one word {0x0005, SEQ_ERR=0, LOST=0, ts=100}; EVT_VALID one cycle after the count pulse.
REQ-039 Counts 0xFFFE, 0xFFFF, 0x0000, 0x0002 -> SEQ_ERR=1 only on 0x0002; SEQ_ERR_CNT=1.
REQ-040 EVT_READY=0 with FIFO_DEPTH=16: 18 events -> 16 stored, DROP_CNT=2, FIFO_FULL=1; after draining, the next event word has LOST=1 and the one after has LOST=0.
REQ-041 TRIGGER_VALID high for 70 cycles with no count -> TMO_CNT=1, no word, FSM back in IDLE; TRIGGER_VALID falling without a count -> TMO_CNT=2.
REQ-042 Reset asserted in WAIT_CNT, then the count pulse arrives -> no word, TMO_CNT=0; the next full handshake after reset has SEQ_ERR=0.
REQ-043 Random EVT_READY back-pressure with continuous triggers -> output order matches input order, EVT_DATA stable while stalled, no loss below full.
